// File: rtl/bsearch_engine_if.sv
// rtl/bsearch_engine_if.sv - probe/response handshake between the search engine and the predicate unit
interface bsearch_engine_if #(
    parameter int WIDTH = 32
);
    logic             q_valid;
    logic             q_ready;
    logic [WIDTH-1:0] q_mid;
    logic             r_valid;
    logic             r_true;

    // Engine side: issues probes, consumes predicate results.
    modport master (
        output q_valid,
        output q_mid,
        input  q_ready,
        input  r_valid,
        input  r_true
    );

    // Predicate unit side: accepts probes, returns pred(q_mid).
    modport slave (
        input  q_valid,
        input  q_mid,
        output q_ready,
        output r_valid,
        output r_true
    );
endinterface

// File: rtl/bsearch_engine.sv
// rtl/bsearch_engine.sv - sequential binary search for the last x in [lo,hi) with pred(x)=0
module bsearch_engine #(
    parameter int WIDTH  = 32,
    parameter int ITER_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WIDTH-1:0]  lo_i,
    input  logic [WIDTH-1:0]  hi_i,
    bsearch_engine_if.master  q_if,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [WIDTH-1:0]  result_o,
    output logic [ITER_W-1:0] iter_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_QUERY,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [ITER_W-1:0] ITER_MAX = '1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  mid_q, mid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
    logic              err_q, err_d;

    // One extra bit so lo+1 cannot wrap when lo is all-ones.
    logic [WIDTH:0]    lo_plus1;
    logic [WIDTH-1:0]  span;

    assign lo_plus1 = {1'b0, lo_q} + {{WIDTH{1'b0}}, 1'b1};
    // hi>lo is invariant here, so the span never underflows and lo+span/2 never overflows.
    assign span     = hi_q - lo_q;

    // Next-state and datapath updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        mid_d      = mid_q;
        result_d   = result_q;
        iter_d     = iter_q;
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lo_d   = lo_i;
                    hi_d   = hi_i;
                    iter_d = '0;
                    err_d  = 1'b0;
                    if (hi_i <= lo_i) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (lo_plus1 < {1'b0, hi_q}) begin
                    mid_d   = lo_q + (span >> 1);
                    state_d = S_QUERY;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_QUERY: begin
                if (q_if.q_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (q_if.r_valid) begin
                    if (q_if.r_true) begin
                        hi_d = mid_q;
                    end else begin
                        lo_d = mid_q;
                    end
                    if (iter_q != ITER_MAX) begin
                        iter_d = iter_q + 1'b1;
                    end
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                result_d   = lo_q;
                iter_cnt_d = iter_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_q != S_IDLE) && abort_i) begin
            state_d    = S_IDLE;
            lo_d       = lo_q;
            hi_d       = hi_q;
            mid_d      = mid_q;
            result_d   = result_q;
            iter_d     = iter_q;
            iter_cnt_d = iter_cnt_q;
            err_d      = err_q;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            mid_q      <= '0;
            result_q   <= '0;
            iter_q     <= '0;
            iter_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            mid_q      <= mid_d;
            result_q   <= result_d;
            iter_q     <= iter_d;
            iter_cnt_q <= iter_cnt_d;
            err_q      <= err_d;
        end
    end

    assign q_if.q_valid = (state_q == S_QUERY);
    assign q_if.q_mid   = mid_q;
    assign busy_o       = (state_q == S_CHECK) || (state_q == S_QUERY) || (state_q == S_WAIT);
    // The result is presented in the same cycle as done; the held copy is only committed if not aborted.
    assign done_o       = (state_q == S_DONE) && !abort_i;
    assign result_o     = done_o ? lo_q : result_q;
    assign iter_count_o = done_o ? iter_q : iter_cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_bsearch_engine.sv
// tb/tb_bsearch_engine.sv - directed self-checking bench for bsearch_engine
module tb_bsearch_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] lo = '0;
    logic [31:0] hi = '0;
    logic        q_ready = 1'b0;
    logic        r_valid = 1'b0;
    logic        r_true = 1'b0;

    always #5 clk = ~clk;

    bsearch_engine_if #(.WIDTH(32)) if32 ();
    bsearch_engine_if #(.WIDTH(8))  if8 ();

    assign if32.q_ready = q_ready;
    assign if32.r_valid = r_valid;
    assign if32.r_true  = r_true;
    assign if8.q_ready  = q_ready;
    assign if8.r_valid  = r_valid;
    assign if8.r_true   = r_true;

    logic        busy32, done32, err32, busy8, done8, err8;
    logic [31:0] res32;
    logic [7:0]  res8;
    logic [5:0]  iter32;
    logic [3:0]  iter8;

    bsearch_engine #(.WIDTH(32)) dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start & ~sel),
        .abort_i      (abort),
        .lo_i         (lo),
        .hi_i         (hi),
        .q_if         (if32),
        .busy_o       (busy32),
        .done_o       (done32),
        .err_o        (err32),
        .result_o     (res32),
        .iter_count_o (iter32)
    );

    bsearch_engine #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start & sel),
        .abort_i      (abort),
        .lo_i         (lo[7:0]),
        .hi_i         (hi[7:0]),
        .q_if         (if8),
        .busy_o       (busy8),
        .done_o       (done8),
        .err_o        (err8),
        .result_o     (res8),
        .iter_count_o (iter8)
    );

    logic        o_q_valid, o_busy, o_done, o_err;
    logic [31:0] o_q_mid, o_result, o_iter;

    assign o_q_valid = sel ? if8.q_valid : if32.q_valid;
    assign o_q_mid   = sel ? {24'b0, if8.q_mid} : if32.q_mid;
    assign o_busy    = sel ? busy8 : busy32;
    assign o_done    = sel ? done8 : done32;
    assign o_err     = sel ? err8 : err32;
    assign o_result  = sel ? {24'b0, res8} : res32;
    assign o_iter    = sel ? {28'b0, iter8} : {26'b0, iter32};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic        r_done, r_err, r_bounds_ok, r_stable_ok, r_dup, r_busy_after, r_timeout;
    logic [31:0] r_res, r_iter;
    int          r_nq, r_dcyc;

    // Drives one search and plays the predicate unit pred(x) = (x >= thr).
    task automatic run_search(input logic s, input logic [31:0] l, input logic [31:0] h,
                              input logic [31:0] thr, input int qd, input int rd, input int ab_iter);
        logic [31:0] m_lo, m_hi, pmid, fmid;
        int          phase, qwait, rwait;
        bit          ab_pend;
        sel = s;
        m_lo = l; m_hi = h; pmid = '0; fmid = '0;
        phase = 0; qwait = 0; rwait = 0; ab_pend = 1'b0;
        r_done = 1'b0; r_err = 1'b0; r_res = '0; r_iter = '0; r_nq = 0; r_dcyc = -1;
        r_bounds_ok = 1'b1; r_stable_ok = 1'b1; r_dup = 1'b0; r_busy_after = 1'b1; r_timeout = 1'b1;
        @(negedge clk);
        lo = l; hi = h; start = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start = 1'b0; q_ready = 1'b0; r_valid = 1'b0; r_true = 1'b0; abort = 1'b0;
            if (ab_pend) begin
                r_busy_after = o_busy;
                r_done       = o_done;
                r_timeout    = 1'b0;
                break;
            end
            if (o_done) begin
                r_done = 1'b1; r_res = o_result; r_err = o_err; r_iter = o_iter;
                r_dcyc = c; r_timeout = 1'b0;
                break;
            end
            if (phase == 0 && o_q_valid) begin
                if (qwait == 0) fmid = o_q_mid;
                else if (o_q_mid != fmid) r_stable_ok = 1'b0;
                if (!(o_q_mid > m_lo && o_q_mid < m_hi)) r_bounds_ok = 1'b0;
                if (qwait >= qd) begin
                    q_ready = 1'b1; r_nq++; pmid = o_q_mid; phase = 1; rwait = 0;
                end else begin
                    qwait++;
                end
            end else if (phase == 1) begin
                if (o_q_valid) r_dup = 1'b1;
                if (r_nq == ab_iter) begin
                    abort = 1'b1; ab_pend = 1'b1;
                end else if (rwait >= rd) begin
                    r_valid = 1'b1;
                    r_true  = (pmid >= thr);
                    if (pmid >= thr) m_hi = pmid;
                    else             m_lo = pmid;
                    phase = 0; qwait = 0;
                end else begin
                    rwait++;
                end
            end
        end
        start = 1'b0; q_ready = 1'b0; r_valid = 1'b0; r_true = 1'b0; abort = 1'b0;
    endtask

    int main_nq;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_err", o_err, 0);
        check_eq("rst_qvalid", o_q_valid, 0);
        check_eq("rst_qmid", o_q_mid, 0);
        check_eq("rst_result", o_result, 0);
        check_eq("rst_iter", o_iter, 0);

        // Main search, zero-wait handshakes.
        run_search(1'b0, 32'h0, 32'h7FFF_FFFF, 32'd1000, 0, 0, -1);
        check_eq("main_timeout", r_timeout, 0);
        check_eq("main_result", r_res, 32'd999);
        check_eq("main_err", r_err, 0);
        check_eq("main_iter", r_iter, r_nq);
        check_eq("main_iter_le31", (r_iter <= 31), 1);
        check_eq("main_bounds", r_bounds_ok, 1);
        check_eq("main_single_hs", r_dup, 0);
        main_nq = r_nq;

        // Adjacent bounds: no probe, done two cycles after start.
        run_search(1'b0, 32'd5, 32'd6, 32'd1000, 0, 0, -1);
        check_eq("adj_result", r_res, 32'd5);
        check_eq("adj_iter", r_iter, 0);
        check_eq("adj_noquery", r_nq, 0);
        check_eq("adj_latency", r_dcyc, 1);
        check_eq("adj_err", r_err, 0);

        // Empty range: error reported, lo passed through.
        run_search(1'b0, 32'd10, 32'd3, 32'd1000, 0, 0, -1);
        check_eq("err_done", r_done, 1);
        check_eq("err_flag", r_err, 1);
        check_eq("err_result", r_res, 32'd10);
        check_eq("err_noquery", r_nq, 0);
        check_eq("err_latency", r_dcyc, 0);

        // Back-pressured handshakes: same answer, stable probe, err cleared.
        run_search(1'b0, 32'h0, 32'h7FFF_FFFF, 32'd1000, 3, 4, -1);
        check_eq("stall_timeout", r_timeout, 0);
        check_eq("stall_result", r_res, 32'd999);
        check_eq("stall_err", r_err, 0);
        check_eq("stall_iter", r_iter, main_nq);
        check_eq("stall_qmid_stable", r_stable_ok, 1);
        check_eq("stall_single_hs", r_dup, 0);
        check_eq("stall_bounds", r_bounds_ok, 1);

        // Abort in WAIT of the 5th probe.
        run_search(1'b0, 32'h0, 32'h7FFF_FFFF, 32'd1000, 0, 0, 5);
        check_eq("abort_busy", r_busy_after, 0);
        check_eq("abort_nodone", r_done, 0);
        check_eq("abort_result_kept", o_result, 32'd999);
        check_eq("abort_iter_kept", o_iter, main_nq);
        check_eq("abort_err_kept", o_err, 0);

        // Restart after abort.
        run_search(1'b0, 32'd100, 32'd200, 32'd150, 0, 0, -1);
        check_eq("restart_result", r_res, 32'd149);
        check_eq("restart_iter", r_iter, r_nq);
        check_eq("restart_bounds", r_bounds_ok, 1);

        // 8-bit instance at the top of its range.
        run_search(1'b1, 32'd0, 32'd255, 32'd255, 0, 0, -1);
        check_eq("w8_timeout", r_timeout, 0);
        check_eq("w8_result", r_res, 32'd254);
        check_eq("w8_err", r_err, 0);
        check_eq("w8_iter", r_iter, r_nq);
        check_eq("w8_bounds", r_bounds_ok, 1);

        // Asynchronous reset while a probe is outstanding.
        sel = 1'b0;
        @(negedge clk);
        lo = 32'd0; hi = 32'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("arst_pre_qvalid", o_q_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_qvalid", o_q_valid, 0);
        check_eq("arst_busy", o_busy, 0);
        check_eq("arst_done", o_done, 0);
        check_eq("arst_err", o_err, 0);
        check_eq("arst_qmid", o_q_mid, 0);
        check_eq("arst_result", o_result, 0);
        check_eq("arst_iter", o_iter, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst_idle_busy", o_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
